ctrl_seq: RTL
=============

CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, meaning number of general registers (2..16).
REQ-002 SHALL have parameter REG_SEL_W, default 4, meaning IR register-field width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clr, input, 1, meaning reset; it is synchronous and active-high.
REQ-005 SHALL have port run, input, 1, meaning start or continue the instruction cycle.
REQ-006 SHALL have port mem_rdy, input, 1, meaning memory read data is valid on Mdatain.
REQ-007 SHALL have port ir, input, 32, meaning current IR contents: op [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
REQ-008 SHALL have 1-bit output strobes Pout, MARen, Pen, Read, MDRen, MDROut, IRen, Yen, ZLOen, ZHIen, ZLOout, ZHIout, HIen and LOen, meaning datapath controls.
REQ-009 SHALL have ports reg_out and reg_en, output, NUM_REGS each, meaning one-hot register bus-drive and register-load.
REQ-010 SHALL have port alu_control, output, 5, meaning ALU operation select.
REQ-011 SHALL have ports busy, done and illegal, output, 1 each, meaning in-cycle status, retire pulse and sticky fault.

Function
REQ-012 SHALL implement states IDLE, T0, T1, T2, T3, T4, T5, T6 and FAULT; every output is a registered decode of the present state.
REQ-013 SHALL leave IDLE for T0 when run=1; busy=1 in every state except IDLE and FAULT.
REQ-014 SHALL in T0 assert Pout, MARen and ZLOen with alu_control=5'b11111 (PC increment).
REQ-015 SHALL in T1 assert ZLOout, Pen, Read and MDRen; it SHALL hold T1 with Pen pulsed only on the first T1 cycle until mem_rdy=1.
REQ-016 SHALL in T2 assert MDROut and IRen.
REQ-017 SHALL in T3 decode ir; an undefined op or any register field >= NUM_REGS SHALL go to FAULT with illegal=1; otherwise it SHALL assert reg_out[Rb] and Yen.
REQ-018 SHALL in T4 assert reg_out[Rc] (reg_out[Rb] for the unary NEG and NOT ops) with alu_control=op and ZLOen; MUL and DIV SHALL also assert ZHIen and drive Ra/Rb instead of Rb/Rc.
REQ-019 SHALL in T5 assert ZLOout and reg_en[Ra]; for MUL and DIV it SHALL assert ZLOout and LOen instead.
REQ-020 SHALL assert ZHIout and HIen in T6, which is reached only for MUL and DIV.
REQ-021 SHALL pulse done for one cycle at the last execute state; it SHALL then enter T0 if run=1, else IDLE.
REQ-022 SHALL define the legal ops as ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001, AND 01010, OR 01011, MUL 01111, DIV 10000, NEG 10001 and NOT 10010.
REQ-023 SHALL have at most one reg_out bit and at most one reg_en bit set in any cycle.
REQ-024 SHALL keep run=0 mid-instruction from aborting the instruction; it only prevents the next fetch.
REQ-025 SHALL leave FAULT only via clr; all strobes are 0 in FAULT.

Reset
REQ-026 SHALL on clr=1 at a clock edge enter IDLE with all strobes, reg_out, reg_en, done and illegal at 0 and alu_control=5'b00000, including mid-instruction.
REQ-027 SHALL give clr priority over run and mem_rdy.

Configuration
REQ-028 SHALL, when macro CTRL_SEQ_MULDIV_EN is defined, support MUL and DIV with T6 and HI/LO writes.
REQ-029 SHALL, without CTRL_SEQ_MULDIV_EN, treat MUL and DIV as illegal, so T6, ZHIen, ZHIout, HIen and LOen are constant 0.

Structure
REQ-030 SHALL take the state enum, opcode constants and ALU_INC=5'b11111 from shared package ctrl_seq_pkg.
REQ-031 SHALL use one sub-module, reg_field_decoder (index + valid -> one-hot NUM_REGS), instantiated for both reg_out and reg_en.

Verification
REQ-032 SHALL verify ir=32'h28918000, mem_rdy=1: T3 reg_out[2], T4 reg_out[3] with alu_control=00101, T5 reg_en[1]; done in the 7th cycle after T0 entry.
REQ-033 SHALL verify mem_rdy held low 3 cycles in T1: T1 lasts 4 cycles, Pen high only in the first, Read high throughout.
REQ-034 SHALL verify MUL ir=32'h78900000 with macro defined: T5 LOen, T6 ZHIout+HIen; with macro undefined: FAULT, illegal=1.
REQ-035 SHALL verify op 11100 or NUM_REGS=8 with Rb=9: FAULT at T3, illegal stays 1 until clr.
REQ-036 SHALL verify clr asserted in T4: next cycle IDLE, all outputs 0; a run held high refetches from T0.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: shared types and constants for the control sequencer.
// Holds the state encoding, the opcode map, the PC-increment ALU code and
// the packed datapath-strobe bundle.
package ctrl_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_FAULT
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam logic [4:0] ALU_INC = 5'b11111;

    // Datapath strobes, MSB first in the order the datapath lists them.
    typedef struct packed {
        logic pout;
        logic maren;
        logic pen;
        logic read;
        logic mdren;
        logic mdrout;
        logic iren;
        logic yen;
        logic zloen;
        logic zhien;
        logic zloout;
        logic zhiout;
        logic hien;
        logic loen;
    } strb_t;

    // Ops that are always legal; MUL/DIV legality depends on the build.
    function automatic logic is_base_op(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
            OP_AND, OP_OR, OP_NEG, OP_NOT: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: instruction-cycle handshake and datapath control bundle.
// master = the sequencer that drives the controls, slave = the datapath side.
interface ctrl_seq_if #(
    parameter int NUM_REGS = 16
);
    logic                run;
    logic                mem_rdy;
    logic [31:0]         ir;
    logic                Pout, MARen, Pen, Read, MDRen, MDROut, IRen, Yen;
    logic                ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen;
    logic [NUM_REGS-1:0] reg_out;
    logic [NUM_REGS-1:0] reg_en;
    logic [4:0]          alu_control;
    logic                busy, done, illegal;

    modport master (
        input  run, mem_rdy, ir,
        output Pout, MARen, Pen, Read, MDRen, MDROut, IRen, Yen,
        output ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen,
        output reg_out, reg_en, alu_control, busy, done, illegal
    );

    modport slave (
        output run, mem_rdy, ir,
        input  Pout, MARen, Pen, Read, MDRen, MDROut, IRen, Yen,
        input  ZLOen, ZHIen, ZLOout, ZHIout, HIen, LOen,
        input  reg_out, reg_en, alu_control, busy, done, illegal
    );
endinterface

// File: rtl/ctrl_seq_reg_field_decoder.sv
// reg_field_decoder: IR register field -> one-hot register select.
// Output is all-zero when i_valid is low, so at most one bit is ever set.
module reg_field_decoder #(
    parameter int NUM_REGS  = 16,
    parameter int REG_SEL_W = 4
) (
    input  logic [REG_SEL_W-1:0] i_idx,
    input  logic                 i_valid,
    output logic [NUM_REGS-1:0]  o_onehot
);
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_bit
        assign o_onehot[g] = i_valid && (i_idx == REG_SEL_W'(g));
    end
endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: fetch/decode/execute control sequencer for a bus-based datapath.
// All outputs are flops loaded with the decode of the present state, so they
// appear in the cycle after the FSM enters a state and are glitch-free.
// Build option: define CTRL_SEQ_MULDIV_EN to enable MUL/DIV (T6, HI/LO writes);
// otherwise MUL/DIV fault like any undefined op.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int REG_SEL_W = 4
) (
    input  logic       clk,
    input  logic       clr,
    ctrl_seq_if.master bus
);

`ifdef CTRL_SEQ_MULDIV_EN
    localparam logic MULDIV_EN = 1'b1;
`else
    localparam logic MULDIV_EN = 1'b0;
`endif

    state_t                r_state, w_nxt;
    logic                  r_in_t1;
    strb_t                 r_strb, w_strb;
    logic [4:0]            r_alu, w_alu;
    logic                  r_busy, w_busy, r_done, w_done, r_ill, w_ill;
    logic [NUM_REGS-1:0]   r_reg_out, r_reg_en, w_reg_out, w_reg_en;
    logic                  w_out_vld, w_en_vld;
    logic [REG_SEL_W-1:0]  w_out_idx, w_en_idx;

    logic [4:0]            w_op;
    logic [REG_SEL_W-1:0]  w_ra, w_rb, w_rc;
    logic                  w_is_muldiv, w_is_unary, w_legal;

    assign w_op = bus.ir[31:27];
    assign w_ra = bus.ir[26 -: REG_SEL_W];
    assign w_rb = bus.ir[22 -: REG_SEL_W];
    assign w_rc = bus.ir[18 -: REG_SEL_W];

    assign w_is_muldiv = MULDIV_EN && ((w_op == OP_MUL) || (w_op == OP_DIV));
    assign w_is_unary  = (w_op == OP_NEG) || (w_op == OP_NOT);
    // Every field is range-checked, even ones the op ignores.
    assign w_legal = (is_base_op(w_op) || w_is_muldiv) &&
                     (int'(w_ra) < NUM_REGS) && (int'(w_rb) < NUM_REGS) &&
                     (int'(w_rc) < NUM_REGS);

    // Next state plus the output decode of the present state.
    always_comb begin
        w_nxt     = r_state;
        w_strb    = '0;
        w_alu     = 5'b00000;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_ill     = 1'b0;
        w_out_vld = 1'b0;
        w_out_idx = w_rb;
        w_en_vld  = 1'b0;
        w_en_idx  = w_ra;
        case (r_state)
            S_IDLE: if (bus.run) w_nxt = S_T0;
            S_T0: begin
                w_busy = 1'b1;
                w_strb.pout = 1'b1; w_strb.maren = 1'b1; w_strb.zloen = 1'b1;
                w_alu = ALU_INC;
                w_nxt = S_T1;
            end
            S_T1: begin
                // PC load only on the first T1 cycle; Read holds while waiting.
                w_busy = 1'b1;
                w_strb.zloout = 1'b1; w_strb.pen = !r_in_t1;
                w_strb.read = 1'b1;   w_strb.mdren = 1'b1;
                if (bus.mem_rdy) w_nxt = S_T2;
            end
            S_T2: begin
                w_busy = 1'b1;
                w_strb.mdrout = 1'b1; w_strb.iren = 1'b1;
                w_nxt = S_T3;
            end
            S_T3: begin
                w_busy = 1'b1;
                if (!w_legal) begin
                    w_nxt = S_FAULT;
                end else begin
                    // MUL/DIV operands are Ra,Rb; everything else Rb,Rc.
                    w_out_vld  = 1'b1;
                    w_out_idx  = w_is_muldiv ? w_ra : w_rb;
                    w_strb.yen = 1'b1;
                    w_nxt      = S_T4;
                end
            end
            S_T4: begin
                w_busy       = 1'b1;
                w_out_vld    = 1'b1;
                w_out_idx    = (w_is_muldiv || w_is_unary) ? w_rb : w_rc;
                w_alu        = w_op;
                w_strb.zloen = 1'b1;
                w_strb.zhien = w_is_muldiv;
                w_nxt        = S_T5;
            end
            S_T5: begin
                w_busy        = 1'b1;
                w_strb.zloout = 1'b1;
                if (w_is_muldiv) begin
                    w_strb.loen = 1'b1;
                    w_nxt       = S_T6;
                end else begin
                    w_en_vld = 1'b1;
                    w_done   = 1'b1;
                    w_nxt    = bus.run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                w_busy        = 1'b1;
                w_strb.zhiout = 1'b1; w_strb.hien = 1'b1;
                w_done        = 1'b1;
                w_nxt         = bus.run ? S_T0 : S_IDLE;
            end
            S_FAULT: w_ill = 1'b1;
            default: w_nxt = S_IDLE;
        endcase
    end

    reg_field_decoder #(.NUM_REGS(NUM_REGS), .REG_SEL_W(REG_SEL_W)) u_dec_out (
        .i_idx    (w_out_idx),
        .i_valid  (w_out_vld),
        .o_onehot (w_reg_out)
    );

    reg_field_decoder #(.NUM_REGS(NUM_REGS), .REG_SEL_W(REG_SEL_W)) u_dec_en (
        .i_idx    (w_en_idx),
        .i_valid  (w_en_vld),
        .o_onehot (w_reg_en)
    );

    // State register and registered outputs; clr wins over everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= S_IDLE;
            r_in_t1   <= 1'b0;
            r_strb    <= '0;
            r_alu     <= 5'b00000;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ill     <= 1'b0;
            r_reg_out <= '0;
            r_reg_en  <= '0;
        end else begin
            r_state   <= w_nxt;
            r_in_t1   <= (r_state == S_T1);
            r_strb    <= w_strb;
            r_alu     <= w_alu;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_ill     <= w_ill;
            r_reg_out <= w_reg_out;
            r_reg_en  <= w_reg_en;
        end
    end

    assign bus.Pout        = r_strb.pout;
    assign bus.MARen       = r_strb.maren;
    assign bus.Pen         = r_strb.pen;
    assign bus.Read        = r_strb.read;
    assign bus.MDRen       = r_strb.mdren;
    assign bus.MDROut      = r_strb.mdrout;
    assign bus.IRen        = r_strb.iren;
    assign bus.Yen         = r_strb.yen;
    assign bus.ZLOen       = r_strb.zloen;
    assign bus.ZHIen       = r_strb.zhien;
    assign bus.ZLOout      = r_strb.zloout;
    assign bus.ZHIout      = r_strb.zhiout;
    assign bus.HIen        = r_strb.hien;
    assign bus.LOen        = r_strb.loen;
    assign bus.reg_out     = r_reg_out;
    assign bus.reg_en      = r_reg_en;
    assign bus.alu_control = r_alu;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.illegal     = r_ill;

endmodule
